// File: rtl/axi_revision_reader_pkg.sv
// Definitions shared by the revision reader, its bus interface and the revision slave:
// register indices, read-response codes and the reader state encoding.
package axi_revision_reader_pkg;

  localparam logic [1:0] REG_MAJOR = 2'd0;
  localparam logic [1:0] REG_MINOR = 2'd1;
  localparam logic [1:0] REG_BUILD = 2'd2;
  localparam logic [1:0] REG_DATE  = 2'd3;

  localparam logic [1:0] RRESP_OKAY   = 2'b00;
  localparam logic [1:0] RRESP_SLVERR = 2'b10;

  typedef logic [1:0] reader_state_t;

  localparam reader_state_t ST_IDLE   = 2'd0;
  localparam reader_state_t ST_ADDR   = 2'd1;
  localparam reader_state_t ST_DATA   = 2'd2;
  localparam reader_state_t ST_FINISH = 2'd3;

endpackage

// File: rtl/axi_revision_reader_if.sv
// AXI4-Lite read-address and read-data channels between the revision reader and its slave.
interface axi_revision_reader_if
  import axi_revision_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] M_AXI_ARADDR;
  logic                  M_AXI_ARVALID;
  logic [2:0]            M_AXI_ARPROT;
  logic                  M_AXI_ARREADY;
  logic [DATA_WIDTH-1:0] M_AXI_RDATA;
  logic [1:0]            M_AXI_RRESP;
  logic                  M_AXI_RVALID;
  logic                  M_AXI_RREADY;

  modport master (
    output M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_ARPROT, M_AXI_RREADY,
    input  M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
  );

  modport slave (
    input  M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_ARPROT, M_AXI_RREADY,
    output M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
  );

endinterface

// File: rtl/axi_revision_reader.sv
// Read-only AXI4-Lite master that fetches the four build-revision registers after reset
// or on request and holds them as parallel outputs.
module axi_revision_reader
  import axi_revision_reader_pkg::*;
#(
  parameter int                          M_AXI_ADDR_WIDTH = 4,
  parameter int                          M_AXI_DATA_WIDTH = 32,
  parameter logic [M_AXI_ADDR_WIDTH-1:0] BASE_ADDR        = '0,
  parameter int                          TIMEOUT_CYCLES   = 1024,
  parameter bit                          AUTO_START       = 1'b1
) (
  input  logic                        AXI_ACLK,
  input  logic                        AXI_ARESETN,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        valid,
  output logic                        error,
  output logic [M_AXI_DATA_WIDTH-1:0] rev_major,
  output logic [M_AXI_DATA_WIDTH-1:0] rev_minor,
  output logic [M_AXI_DATA_WIDTH-1:0] rev_build,
  output logic [M_AXI_DATA_WIDTH-1:0] rev_date,
  axi_revision_reader_if.master       m_axi
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // The counter restarts at zero on state entry, so stopping at T-2 leaves T-1 waiting cycles.
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 2);

  reader_state_t state;
  logic [1:0]    idx;
  logic [CW-1:0] tmo_cnt;
  logic          kick;

  always_comb begin
    busy                = (state == ST_ADDR) || (state == ST_DATA);
    done                = (state == ST_FINISH);
    m_axi.M_AXI_ARVALID = (state == ST_ADDR);
    m_axi.M_AXI_RREADY  = (state == ST_DATA);
    m_axi.M_AXI_ARADDR  = BASE_ADDR + M_AXI_ADDR_WIDTH'({idx, 2'b00});
    m_axi.M_AXI_ARPROT  = 3'b000;
  end

  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_ARESETN) begin
      state     <= ST_IDLE;
      idx       <= REG_MAJOR;
      tmo_cnt   <= '0;
      kick      <= AUTO_START;
      valid     <= 1'b0;
      error     <= 1'b0;
      rev_major <= '0;
      rev_minor <= '0;
      rev_build <= '0;
      rev_date  <= '0;
    end else begin
      kick <= 1'b0;
      case (state)
        ST_ADDR: begin
          if (m_axi.M_AXI_ARREADY) begin
            state   <= ST_DATA;
            tmo_cnt <= '0;
          end else if (tmo_cnt == TMO_LAST) begin
            error <= 1'b1;
            state <= ST_FINISH;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (m_axi.M_AXI_RVALID) begin
            case (idx)
              REG_MAJOR: rev_major <= m_axi.M_AXI_RDATA;
              REG_MINOR: rev_minor <= m_axi.M_AXI_RDATA;
              REG_BUILD: rev_build <= m_axi.M_AXI_RDATA;
              default:   rev_date  <= m_axi.M_AXI_RDATA;
            endcase
            if (m_axi.M_AXI_RRESP != RRESP_OKAY) begin
              error <= 1'b1;
            end
            // A bad response only flags the fetch; the remaining registers are still read.
            if (idx == REG_DATE) begin
              valid <= !error && (m_axi.M_AXI_RRESP == RRESP_OKAY);
              state <= ST_FINISH;
            end else begin
              idx     <= idx + 2'd1;
              tmo_cnt <= '0;
              state   <= ST_ADDR;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            error <= 1'b1;
            state <= ST_FINISH;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: begin
          if (start || kick) begin
            valid   <= 1'b0;
            error   <= 1'b0;
            idx     <= REG_MAJOR;
            tmo_cnt <= '0;
            state   <= ST_ADDR;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_revision_reader.sv
// Directed bench for axi_revision_reader: a negedge-driven slave model with configurable
// delays, error response and hang, and hand-computed expectations for each scenario.
module tb_axi_revision_reader;
  import axi_revision_reader_pkg::*;

  logic        AXI_ACLK = 1'b0;
  logic        AXI_ARESETN = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, valid, error;
  logic [31:0] rev_major, rev_minor, rev_build, rev_date;

  axi_revision_reader_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) axi_bus ();

  axi_revision_reader #(
    .M_AXI_ADDR_WIDTH(4),
    .M_AXI_DATA_WIDTH(32),
    .BASE_ADDR(4'h0),
    .TIMEOUT_CYCLES(16),
    .AUTO_START(1'b1)
  ) dut (
    .AXI_ACLK(AXI_ACLK),
    .AXI_ARESETN(AXI_ARESETN),
    .start(start),
    .busy(busy),
    .done(done),
    .valid(valid),
    .error(error),
    .rev_major(rev_major),
    .rev_minor(rev_minor),
    .rev_build(rev_build),
    .rev_date(rev_date),
    .m_axi(axi_bus)
  );

  always #5 AXI_ACLK = ~AXI_ACLK;

  int total = 0;
  int bad = 0;

  int          ar_delay = 0;
  int          r_delay = 0;
  int          bad_idx = -1;
  int          hang_idx = -1;
  logic [31:0] reg_table [4];

  int         n_req = 0;
  logic [3:0] addr_log [16];
  int         done_cnt = 0;
  int         addr_unstable = 0;
  int         rready_run = 0;
  int         rready_max = 0;
  int         overlap = 0;

  // Slave model: acts on the falling edge so the DUT sees settled inputs on the rising edge.
  initial begin
    logic       prev_arvalid, prev_rready, pending;
    int         ar_cnt, r_cnt;
    logic [3:0] cur_addr;
    prev_arvalid = 1'b0;
    prev_rready  = 1'b0;
    pending      = 1'b0;
    ar_cnt       = 0;
    r_cnt        = 0;
    cur_addr     = '0;
    axi_bus.M_AXI_ARREADY = 1'b0;
    axi_bus.M_AXI_RVALID  = 1'b0;
    axi_bus.M_AXI_RDATA   = '0;
    axi_bus.M_AXI_RRESP   = 2'b00;
    forever begin
      @(negedge AXI_ACLK);
      if (!AXI_ARESETN || !busy) begin
        axi_bus.M_AXI_ARREADY = 1'b0;
        axi_bus.M_AXI_RVALID  = 1'b0;
        pending = 1'b0;
        ar_cnt  = 0;
        r_cnt   = 0;
      end else begin
        if (axi_bus.M_AXI_ARREADY && prev_arvalid) begin
          axi_bus.M_AXI_ARREADY = 1'b0;
          pending = 1'b1;
          ar_cnt  = 0;
          r_cnt   = 0;
        end
        if (axi_bus.M_AXI_RVALID && prev_rready) begin
          axi_bus.M_AXI_RVALID = 1'b0;
          pending = 1'b0;
        end
        if (axi_bus.M_AXI_ARVALID && !axi_bus.M_AXI_ARREADY) begin
          if (ar_cnt == 0) begin
            cur_addr = axi_bus.M_AXI_ARADDR;
            if (n_req < 16) addr_log[n_req] = axi_bus.M_AXI_ARADDR;
            n_req++;
          end else if (axi_bus.M_AXI_ARADDR !== cur_addr) begin
            addr_unstable++;
          end
          if (ar_cnt >= ar_delay) axi_bus.M_AXI_ARREADY = 1'b1;
          else ar_cnt++;
        end
        if (pending && !axi_bus.M_AXI_RVALID && int'(cur_addr[3:2]) != hang_idx) begin
          if (r_cnt >= r_delay) begin
            axi_bus.M_AXI_RVALID = 1'b1;
            axi_bus.M_AXI_RDATA  = reg_table[cur_addr[3:2]];
            axi_bus.M_AXI_RRESP  = (int'(cur_addr[3:2]) == bad_idx) ? RRESP_SLVERR : RRESP_OKAY;
          end else begin
            r_cnt++;
          end
        end
      end
      prev_arvalid = axi_bus.M_AXI_ARVALID;
      prev_rready  = axi_bus.M_AXI_RREADY;
    end
  end

  // Bus monitor for done pulses, RREADY wait runs and channel overlap.
  initial begin
    forever begin
      @(negedge AXI_ACLK);
      if (done) done_cnt++;
      if (axi_bus.M_AXI_ARVALID && axi_bus.M_AXI_RREADY) overlap++;
      if (axi_bus.M_AXI_RREADY) begin
        rready_run++;
        if (rready_run > rready_max) rready_max = rready_run;
      end else begin
        rready_run = 0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    @(negedge AXI_ACLK);
    start = 1'b1;
    @(negedge AXI_ACLK);
    start = 1'b0;
  endtask

  task automatic clearObs();
    n_req = 0;
    done_cnt = 0;
    addr_unstable = 0;
    rready_max = 0;
    overlap = 0;
  endtask

  task automatic waitDone(input int budget, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge AXI_ACLK);
      if (done) seen = 1'b1;
    end
    total++;
    assert (seen)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=no_done expected=done_within_%0d", tag, budget);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge AXI_ACLK);
  endtask

  initial begin
    bit seen;
    reg_table[0] = 32'h0000_0001;
    reg_table[1] = 32'h0000_0002;
    reg_table[2] = 32'h0000_03E8;
    reg_table[3] = 32'h071A_07E6;

    $display("[TB] reset state");
    settle(2);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_valid", 32'(valid), 32'd0);
    checkOutput("rst_error", 32'(error), 32'd0);
    checkOutput("rst_arvalid", 32'(axi_bus.M_AXI_ARVALID), 32'd0);
    checkOutput("rst_rready", 32'(axi_bus.M_AXI_RREADY), 32'd0);
    checkOutput("rst_araddr", 32'(axi_bus.M_AXI_ARADDR), 32'h0);
    checkOutput("rst_arprot", 32'(axi_bus.M_AXI_ARPROT), 32'd0);
    checkOutput("rst_rev_major", rev_major, 32'h0);
    clearObs();
    AXI_ARESETN = 1'b1;

    $display("[TB] auto-start fetch, zero-wait slave");
    waitDone(200, "auto_done");
    checkOutput("auto_valid", 32'(valid), 32'd1);
    checkOutput("auto_error", 32'(error), 32'd0);
    checkOutput("auto_busy_at_done", 32'(busy), 32'd0);
    checkOutput("auto_major", rev_major, 32'h0000_0001);
    checkOutput("auto_minor", rev_minor, 32'h0000_0002);
    checkOutput("auto_build", rev_build, 32'h0000_03E8);
    checkOutput("auto_date", rev_date, 32'h071A_07E6);
    settle(3);
    checkOutput("auto_done_count", 32'(done_cnt), 32'd1);
    checkOutput("auto_reads", 32'(n_req), 32'd4);
    checkOutput("auto_addr0", 32'(addr_log[0]), 32'h0);
    checkOutput("auto_addr1", 32'(addr_log[1]), 32'h4);
    checkOutput("auto_addr2", 32'(addr_log[2]), 32'h8);
    checkOutput("auto_addr3", 32'(addr_log[3]), 32'hC);
    checkOutput("auto_overlap", 32'(overlap), 32'd0);

    $display("[TB] slow slave");
    ar_delay = 5;
    r_delay = 7;
    clearObs();
    applyStimulus();
    waitDone(300, "slow_done");
    checkOutput("slow_valid", 32'(valid), 32'd1);
    checkOutput("slow_major", rev_major, 32'h0000_0001);
    checkOutput("slow_date", rev_date, 32'h071A_07E6);
    settle(2);
    checkOutput("slow_reads", 32'(n_req), 32'd4);
    checkOutput("slow_addr_unstable", 32'(addr_unstable), 32'd0);
    checkOutput("slow_rready_max", 32'(rready_max), 32'd8);
    checkOutput("slow_overlap", 32'(overlap), 32'd0);

    $display("[TB] SLVERR on build register");
    ar_delay = 0;
    r_delay = 0;
    bad_idx = 2;
    reg_table[2] = 32'hBAD0_0333;
    clearObs();
    applyStimulus();
    waitDone(200, "slverr_done");
    checkOutput("slverr_error", 32'(error), 32'd1);
    checkOutput("slverr_valid", 32'(valid), 32'd0);
    checkOutput("slverr_build", rev_build, 32'hBAD0_0333);
    checkOutput("slverr_date", rev_date, 32'h071A_07E6);
    settle(2);
    checkOutput("slverr_reads", 32'(n_req), 32'd4);

    $display("[TB] hung slave on minor read");
    bad_idx = -1;
    hang_idx = 1;
    reg_table[0] = 32'hA000_0001;
    reg_table[1] = 32'hA000_0002;
    reg_table[2] = 32'hA000_0003;
    reg_table[3] = 32'hA000_0004;
    clearObs();
    applyStimulus();
    waitDone(200, "tmo_done");
    checkOutput("tmo_error", 32'(error), 32'd1);
    checkOutput("tmo_valid", 32'(valid), 32'd0);
    checkOutput("tmo_major", rev_major, 32'hA000_0001);
    checkOutput("tmo_minor", rev_minor, 32'h0000_0002);
    checkOutput("tmo_build", rev_build, 32'hBAD0_0333);
    checkOutput("tmo_date", rev_date, 32'h071A_07E6);
    checkOutput("tmo_arvalid", 32'(axi_bus.M_AXI_ARVALID), 32'd0);
    checkOutput("tmo_rready", 32'(axi_bus.M_AXI_RREADY), 32'd0);
    settle(2);
    checkOutput("tmo_rready_wait", 32'(rready_max), 32'd15);
    checkOutput("tmo_reads", 32'(n_req), 32'd2);
    checkOutput("tmo_done_count", 32'(done_cnt), 32'd1);

    $display("[TB] start while busy, then start after done");
    hang_idx = -1;
    reg_table[0] = 32'h0000_0001;
    reg_table[1] = 32'h0000_0002;
    reg_table[2] = 32'h0000_03E8;
    reg_table[3] = 32'h071A_07E6;
    clearObs();
    applyStimulus();
    checkOutput("start_arvalid", 32'(axi_bus.M_AXI_ARVALID), 32'd1);
    checkOutput("start_busy", 32'(busy), 32'd1);
    settle(2);
    applyStimulus();
    waitDone(200, "ignore_done");
    settle(3);
    checkOutput("ignore_reads", 32'(n_req), 32'd4);
    checkOutput("ignore_done_count", 32'(done_cnt), 32'd1);
    checkOutput("ignore_valid", 32'(valid), 32'd1);
    applyStimulus();
    checkOutput("restart_arvalid", 32'(axi_bus.M_AXI_ARVALID), 32'd1);
    checkOutput("restart_busy", 32'(busy), 32'd1);
    checkOutput("restart_araddr", 32'(axi_bus.M_AXI_ARADDR), 32'h0);
    waitDone(200, "restart_done");

    $display("[TB] reset during build-register data phase");
    r_delay = 7;
    clearObs();
    applyStimulus();
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge AXI_ACLK);
      if (axi_bus.M_AXI_RREADY && axi_bus.M_AXI_ARADDR == 4'h8) seen = 1'b1;
    end
    checkOutput("midrst_reached_data2", 32'(seen), 32'd1);
    AXI_ARESETN = 1'b0;
    @(negedge AXI_ACLK);
    checkOutput("midrst_arvalid", 32'(axi_bus.M_AXI_ARVALID), 32'd0);
    checkOutput("midrst_rready", 32'(axi_bus.M_AXI_RREADY), 32'd0);
    checkOutput("midrst_araddr", 32'(axi_bus.M_AXI_ARADDR), 32'h0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_valid", 32'(valid), 32'd0);
    checkOutput("midrst_error", 32'(error), 32'd0);
    checkOutput("midrst_major", rev_major, 32'h0);
    checkOutput("midrst_minor", rev_minor, 32'h0);
    checkOutput("midrst_build", rev_build, 32'h0);
    checkOutput("midrst_date", rev_date, 32'h0);
    clearObs();
    AXI_ARESETN = 1'b1;
    waitDone(300, "midrst_refetch_done");
    checkOutput("midrst_refetch_valid", 32'(valid), 32'd1);
    checkOutput("midrst_refetch_build", rev_build, 32'h0000_03E8);
    settle(2);
    checkOutput("midrst_refetch_addr0", 32'(addr_log[0]), 32'h0);
    checkOutput("midrst_refetch_reads", 32'(n_req), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
